// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder with a small control FSM.
//
// A request on start (taken only while ready=1) captures both operands. The
// block then adds them LSB first, one bit per clock, through a single
// full-adder slice built from two half adders. The sum and carry-out are
// registered, and done pulses once for each completed addition.
//
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   synchronous active-low reset
//   start  in   request a new addition (sampled only in IDLE)
//   a, b   in   WIDTH-bit operands, captured on the accepted start edge
//   ready  out  high only in IDLE
//   busy   out  high only in ADD
//   done   out  one-cycle pulse when sum/cout have just been updated
//   sum    out  registered low WIDTH bits of a+b
//   cout   out  registered carry-out of a+b
module serial_add_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // Counter has one spare bit so it can represent WIDTH itself.
    localparam int unsigned CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] acc;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic s1_c;
    logic c1_c;
    logic s_c;
    logic c2_c;
    logic cy_next_c;

    // Full-adder slice: two half-adder stages on the current operand LSBs.
    assign s1_c      = opa[0] ^ opb[0];
    assign c1_c      = opa[0] & opb[0];
    assign s_c       = s1_c ^ carry;
    assign c2_c      = s1_c & carry;
    assign cy_next_c = c1_c | c2_c;

    // Control FSM together with the serial datapath.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            opa   <= '0;
            opb   <= '0;
            acc   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ready <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        opa   <= a;
                        opb   <= b;
                        acc   <= '0;
                        carry <= 1'b0;
                        cnt   <= '0;
                        state <= ADD;
                        ready <= 1'b0;
                        busy  <= 1'b1;
                    end
                end

                ADD: begin
                    // Result bits enter at the MSB; after WIDTH shifts bit 0 sits at the LSB.
                    acc   <= {s_c, acc[WIDTH-1:1]};
                    carry <= cy_next_c;
                    opa   <= {1'b0, opa[WIDTH-1:1]};
                    opb   <= {1'b0, opb[WIDTH-1:1]};
                    cnt   <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        sum   <= {s_c, acc[WIDTH-1:1]};
                        cout  <= cy_next_c;
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end

                DONE: begin
                    // Always return to IDLE; a start seen here is dropped.
                    state <= IDLE;
                    done  <= 1'b0;
                    ready <= 1'b1;
                end

                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl at WIDTH=8: directed vectors with
// hand-computed results, start-while-busy, mid-operation reset, held start,
// and a batch of random operands checked against a+b.
module tb_serial_add_ctrl;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int           n_total = 0;
    int           n_bad   = 0;
    logic [W-1:0] held_sum;
    logic         held_cout;

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full operation from IDLE, checking handshake, latency and result.
    task automatic run_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                          input logic [W-1:0] exp_sum, input logic exp_cout,
                          input string tag);
        int n;
        chk({tag, "_ready_pre"}, 64'(ready), 64'(1));
        start = 1'b1;
        a     = op_a;
        b     = op_b;
        tick();
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        chk({tag, "_busy"}, 64'(busy), 64'(1));
        chk({tag, "_ready_busy"}, 64'(ready), 64'(0));
        n = 0;
        while (!done && n < 40) begin
            if (n == 3) begin
                chk({tag, "_sum_hold"}, 64'(sum), 64'(held_sum));
                chk({tag, "_cout_hold"}, 64'(cout), 64'(held_cout));
            end
            tick();
            n++;
        end
        chk({tag, "_latency"}, 64'(n), 64'(W));
        chk({tag, "_sum"}, 64'(sum), 64'(exp_sum));
        chk({tag, "_cout"}, 64'(cout), 64'(exp_cout));
        chk({tag, "_busy_done"}, 64'(busy), 64'(0));
        tick();
        chk({tag, "_done_pulse"}, 64'(done), 64'(0));
        chk({tag, "_ready_post"}, 64'(ready), 64'(1));
        held_sum  = exp_sum;
        held_cout = exp_cout;
    endtask

    initial begin
        int n;
        int ndone;
        int nready;
        int last_done;
        int first_done;
        logic [W:0] full;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        rst_n = 1'b0;
        start = 1'b1;
        a     = 8'hAA;
        b     = 8'h55;
        tick();
        tick();
        chk("rst_ready", 64'(ready), 64'(1));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_sum", 64'(sum), 64'(0));
        chk("rst_cout", 64'(cout), 64'(0));
        start = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("rst_ready_after", 64'(ready), 64'(1));
        held_sum  = '0;
        held_cout = 1'b0;

        // Directed vectors.
        run_op(8'h01, 8'h01, 8'h02, 1'b0, "one_one");
        run_op(8'hFF, 8'h01, 8'h00, 1'b1, "ff_01");
        run_op(8'hFF, 8'hFF, 8'hFE, 1'b1, "ff_ff");
        run_op(8'h00, 8'h00, 8'h00, 1'b0, "zero");

        // start pulsed during ADD is ignored and not queued.
        start = 1'b1;
        a     = 8'h35;
        b     = 8'h4A;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        start = 1'b1;
        a     = 8'hFF;
        b     = 8'hFF;
        tick();
        start = 1'b0;
        n = 4;
        while (!done && n < 40) begin
            tick();
            n++;
        end
        chk("ign_latency", 64'(n), 64'(W));
        chk("ign_sum", 64'(sum), 64'(8'h7F));
        chk("ign_cout", 64'(cout), 64'(0));
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done) ndone++;
        end
        chk("ign_no_second_done", 64'(ndone), 64'(0));
        chk("ign_ready", 64'(ready), 64'(1));
        held_sum  = 8'h7F;
        held_cout = 1'b0;

        // Reset in the middle of ADD aborts with no done and clears results.
        start = 1'b1;
        a     = 8'h80;
        b     = 8'h80;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("abort_ready", 64'(ready), 64'(1));
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_done", 64'(done), 64'(0));
        chk("abort_sum", 64'(sum), 64'(0));
        chk("abort_cout", 64'(cout), 64'(0));
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) ndone++;
        end
        chk("abort_no_done", 64'(ndone), 64'(0));
        held_sum  = '0;
        held_cout = 1'b0;
        run_op(8'h80, 8'h80, 8'h00, 1'b1, "after_abort");

        // start held high: one result every W+2 cycles, ready one cycle between.
        start      = 1'b1;
        a          = 8'h12;
        b          = 8'h34;
        ndone      = 0;
        nready     = 0;
        last_done  = -1;
        first_done = -1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (done) begin
                ndone++;
                chk("hold_sum", 64'(sum), 64'(8'h46));
                chk("hold_cout", 64'(cout), 64'(0));
                if (last_done >= 0) chk("hold_spacing", 64'(i - last_done), 64'(W + 2));
                else first_done = i;
                last_done = i;
            end
            if (ready) nready++;
        end
        start = 1'b0;
        chk("hold_first_done", 64'(first_done), 64'(W));
        chk("hold_done_count", 64'(ndone), 64'(3));
        chk("hold_ready_count", 64'(nready), 64'(3));
        tick();
        tick();
        held_sum  = 8'h46;
        held_cout = 1'b0;

        // Random operands against the bench's own a+b.
        for (int i = 0; i < 1000; i++) begin
            ra   = W'($urandom);
            rb   = W'($urandom);
            full = (W + 1)'(ra) + (W + 1)'(rb);
            run_op(ra, rb, full[W-1:0], full[W], "rand");
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
